// File: rtl/aes_selftest_pkg.sv
// Shared definitions for the AES known-answer self-test controller:
// FSM state encoding, engine key-size codes and the FIPS-197 test vectors.
package aes_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL_MODE = 3'd1,
    ST_ENC_REQ  = 3'd2,
    ST_ENC_WAIT = 3'd3,
    ST_DEC_REQ  = 3'd4,
    ST_DEC_WAIT = 3'd5,
    ST_CHECK    = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Key-size codes as presented on eng_keysize; also used as the mode index.
  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  // Keys are MSB-aligned in a 256-bit field; unused low bits are zero.
  localparam logic [255:0] KAT_KEY_128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KAT_KEY_192 =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KAT_KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [127:0] KAT_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT_CT_256 = 128'h8ea2b7ca516745bfeafc49089b4996e8;

  // Known-answer key for a mode index.
  function automatic logic [255:0] kat_key(input logic [1:0] ks);
    case (ks)
      KS_128:  return KAT_KEY_128;
      KS_192:  return KAT_KEY_192;
      KS_256:  return KAT_KEY_256;
      default: return '0;
    endcase
  endfunction

  // Expected ciphertext of KAT_PT under the mode's known-answer key.
  function automatic logic [127:0] kat_ct(input logic [1:0] ks);
    case (ks)
      KS_128:  return KAT_CT_128;
      KS_192:  return KAT_CT_192;
      KS_256:  return KAT_CT_256;
      default: return '0;
    endcase
  endfunction

  // Lowest mode index set in avail; only meaningful when avail != 0.
  function automatic logic [1:0] first_mode(input logic [2:0] avail);
    if (avail[0])      return KS_128;
    else if (avail[1]) return KS_192;
    else               return KS_256;
  endfunction

endpackage

// File: rtl/aes_selftest_ctrl.sv
// AES known-answer self-test sequencer. For each enabled key size it sends
// an encrypt of the fixed plaintext, then a decrypt of the returned
// ciphertext, and flags the mode as passed when the ciphertext matches the
// known answer and the round trip restores the plaintext.
//
// Engine request handshake: eng_req_valid is registered; while it is high,
// eng_decrypt, eng_keysize, eng_key and eng_data_in are held stable, and the
// request is transferred on the rising edge where eng_req_valid && eng_req_ready.
// eng_req_valid drops on that same edge. Responses are single-cycle strobes on
// eng_rsp_valid, only honoured in the WAIT states, first sampled on the cycle
// after the request transfer.
module aes_selftest_ctrl
  import aes_selftest_pkg::*;
#(
  parameter logic [2:0]  MODE_MASK   = 3'b111,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         eng_req_valid,
  input  logic         eng_req_ready,
  output logic         eng_decrypt,
  output logic [1:0]   eng_keysize,
  output logic [255:0] eng_key,
  output logic [127:0] eng_data_in,
  input  logic         eng_rsp_valid,
  input  logic [127:0] eng_data_out,
  output logic [2:0]   pass,
  output logic [2:0]   fail,
  output logic         timeout_err,
  output logic [2:0]   led,
  output state_e       dbg_state
);

  // Timer counts 0..TIMEOUT_CYC-1 cycles spent in a REQ/WAIT state.
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state;
  logic [2:0]    tested;
  logic [1:0]    mode;
  logic [TW-1:0] timer;
  logic [127:0]  ct;
  logic [127:0]  rt;

  logic [2:0]    avail;
  logic [1:0]    sel;
  logic [2:0]    sel_bit;
  logic [2:0]    mode_bit;
  logic          tmo_hit;

  // Next mode to test, one-hot flags for selected/current mode, timeout tap.
  always_comb begin
    avail    = MODE_MASK & ~tested;
    sel      = first_mode(avail);
    sel_bit  = 3'(3'b001 << sel);
    mode_bit = 3'(3'b001 << mode);
    tmo_hit  = (timer == TMO_LAST);
  end

  assign led       = pass;
  assign dbg_state = state;

  // Self-test sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      eng_req_valid <= 1'b0;
      eng_decrypt   <= 1'b0;
      eng_keysize   <= KS_128;
      eng_key       <= '0;
      eng_data_in   <= '0;
      pass          <= '0;
      fail          <= '0;
      timeout_err   <= 1'b0;
      tested        <= '0;
      mode          <= KS_128;
      timer         <= '0;
      ct            <= '0;
      rt            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass        <= '0;
            fail        <= '0;
            timeout_err <= 1'b0;
            tested      <= '0;
            busy        <= 1'b1;
            state       <= ST_SEL_MODE;
          end
        end

        ST_SEL_MODE: begin
          if (avail == 3'b000) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            mode          <= sel;
            tested        <= tested | sel_bit;
            eng_keysize   <= sel;
            eng_key       <= kat_key(sel);
            eng_data_in   <= KAT_PT;
            eng_decrypt   <= 1'b0;
            eng_req_valid <= 1'b1;
            timer         <= '0;
            state         <= ST_ENC_REQ;
          end
        end

        ST_ENC_REQ, ST_DEC_REQ: begin
          if (eng_req_valid && eng_req_ready) begin
            eng_req_valid <= 1'b0;
            timer         <= '0;
            state         <= (state == ST_ENC_REQ) ? ST_ENC_WAIT : ST_DEC_WAIT;
          end else if (tmo_hit) begin
            fail          <= fail | mode_bit;
            timeout_err   <= 1'b1;
            eng_req_valid <= 1'b0;
            state         <= ST_SEL_MODE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_ENC_WAIT: begin
          if (eng_rsp_valid) begin
            // Ciphertext becomes both the check operand and the decrypt input.
            ct            <= eng_data_out;
            eng_data_in   <= eng_data_out;
            eng_decrypt   <= 1'b1;
            eng_req_valid <= 1'b1;
            timer         <= '0;
            state         <= ST_DEC_REQ;
          end else if (tmo_hit) begin
            fail        <= fail | mode_bit;
            timeout_err <= 1'b1;
            state       <= ST_SEL_MODE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DEC_WAIT: begin
          if (eng_rsp_valid) begin
            rt    <= eng_data_out;
            state <= ST_CHECK;
          end else if (tmo_hit) begin
            fail        <= fail | mode_bit;
            timeout_err <= 1'b1;
            state       <= ST_SEL_MODE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_CHECK: begin
          if ((ct == kat_ct(mode)) && (rt == KAT_PT)) pass <= pass | mode_bit;
          else                                        fail <= fail | mode_bit;
          state <= ST_SEL_MODE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Bench for aes_selftest_ctrl: a behavioural KAT engine behind the request
// handshake, a request-order scoreboard, per-cycle protocol checks and
// directed scenarios with literal expected flag values.
`timescale 1ns/1ps
module tb_aes_selftest_ctrl;
  import aes_selftest_pkg::*;

  localparam int TMO = 16;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: all modes, short timeout ----------------
  logic         start = 1'b0;
  logic         busy, done, req_valid, decrypt, tmo_err;
  logic         req_ready = 1'b1;
  logic         rsp_valid = 1'b0;
  logic [127:0] data_out = '0;
  logic [1:0]   keysize;
  logic [255:0] key;
  logic [127:0] data_in;
  logic [2:0]   pass, fail, led;
  state_e       dbg_state;

  aes_selftest_ctrl #(.MODE_MASK(3'b111), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .eng_req_valid(req_valid), .eng_req_ready(req_ready), .eng_decrypt(decrypt),
    .eng_keysize(keysize), .eng_key(key), .eng_data_in(data_in),
    .eng_rsp_valid(rsp_valid), .eng_data_out(data_out), .pass(pass), .fail(fail),
    .timeout_err(tmo_err), .led(led), .dbg_state(dbg_state)
  );

  // ---------------- DUT Z: no modes enabled ----------------
  logic         start_z = 1'b0;
  logic         busy_z, done_z, req_valid_z, decrypt_z, tmo_err_z;
  logic         req_ready_z = 1'b0;
  logic         rsp_valid_z = 1'b0;
  logic [127:0] data_out_z = '0;
  logic [1:0]   keysize_z;
  logic [255:0] key_z;
  logic [127:0] data_in_z;
  logic [2:0]   pass_z, fail_z, led_z;
  state_e       dbg_state_z;

  aes_selftest_ctrl #(.MODE_MASK(3'b000), .TIMEOUT_CYC(TMO)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .busy(busy_z), .done(done_z),
    .eng_req_valid(req_valid_z), .eng_req_ready(req_ready_z), .eng_decrypt(decrypt_z),
    .eng_keysize(keysize_z), .eng_key(key_z), .eng_data_in(data_in_z),
    .eng_rsp_valid(rsp_valid_z), .eng_data_out(data_out_z), .pass(pass_z), .fail(fail_z),
    .timeout_err(tmo_err_z), .led(led_z), .dbg_state(dbg_state_z)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench-owned known-answer tables.
  function automatic logic [255:0] exp_key(input int ks);
    case (ks)
      0:       return {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      1:       return {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      2:       return 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      default: return '1;
    endcase
  endfunction

  function automatic logic [127:0] exp_ct(input int ks);
    case (ks)
      0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      2:       return 128'h8ea2b7ca516745bfeafc49089b4996e8;
      default: return '1;
    endcase
  endfunction

  // ---------------- engine model ----------------
  bit           corrupt192 = 1'b0;
  bit           stall256   = 1'b0;
  bit           junk_rsp   = 1'b0;
  int           ready_hold = 0;
  int           rsp_cnt    = 0;
  logic [127:0] rsp_data   = '0;
  logic [127:0] last_ct [3];
  int           eng_ks;
  logic [127:0] eng_res;

  initial begin
    for (int i = 0; i < 3; i++) last_ct[i] = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      data_out  = {$urandom, $urandom, $urandom, $urandom};
      if (!rst_n) begin
        rsp_cnt   = 0;
        req_ready = 1'b1;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            rsp_valid = 1'b1;
            data_out  = rsp_data;
          end
        end
        if (req_valid && ready_hold > 0) begin
          req_ready = 1'b0;
          ready_hold--;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            eng_ks = int'(keysize);
            if (!decrypt) begin
              if (data_in == PT && key == exp_key(eng_ks)) eng_res = exp_ct(eng_ks);
              else eng_res = data_in ^ key[127:0] ^ 128'h5a;
              if (corrupt192 && eng_ks == 1) eng_res[0] = ~eng_res[0];
              if (eng_ks < 3) last_ct[eng_ks] = eng_res;
            end else begin
              eng_res = (eng_ks < 3 && data_in == last_ct[eng_ks]) ? PT : ~data_in;
            end
            if (!(stall256 && eng_ks == 2 && !decrypt)) begin
              rsp_cnt  = 3;
              rsp_data = eng_res;
            end
            // A strobe coinciding with the transfer must be ignored.
            if (junk_rsp) begin
              rsp_valid = 1'b1;
              data_out  = ~eng_res;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [2:0]   exp_q [$];          // {decrypt, keysize} in expected order
  int           run_lens [$];       // cycles valid was high per transfer
  int           done_cnt  = 0;
  int           acc256_cyc = -1;
  int           valid_run = 0;
  logic         pv_valid = 1'b0, pv_ready = 1'b0, pv_dec = 1'b0;
  logic [1:0]   pv_ks = '0;
  logic [255:0] pv_key = '0;
  logic [127:0] pv_data = '0;
  logic [2:0]   mon_e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv_valid  = 1'b0;
        valid_run = 0;
      end else begin
        chk("led_eq_pass", led, pass);
        if (done) begin
          done_cnt++;
          chk("busy_low_at_done", busy, 1'b0);
        end
        if (pv_valid && !pv_ready) begin
          chk("valid_held", req_valid, 1'b1);
          chk("key_held", key, pv_key);
          chk("data_held", data_in, pv_data);
          chk("dir_held", decrypt, pv_dec);
          chk("ks_held", keysize, pv_ks);
        end
        if (req_valid) valid_run++;
        if (req_valid && req_ready) begin
          run_lens.push_back(valid_run);
          valid_run = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_request", 1'b1, 1'b0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("req_keysize", keysize, mon_e[1:0]);
            chk("req_dir", decrypt, mon_e[2]);
            chk("req_key", key, exp_key(int'(mon_e[1:0])));
            chk("req_data", data_in, mon_e[2] ? last_ct[mon_e[1:0]] : PT);
          end
          if (keysize == 2'd2 && !decrypt) acc256_cyc = cyc;
        end
        pv_valid = req_valid;
        pv_ready = req_ready;
        pv_dec   = decrypt;
        pv_ks    = keysize;
        pv_key   = key;
        pv_data  = data_in;
      end
    end
  end

  // Expected request sequence: ascending modes, encrypt then decrypt,
  // no decrypt after an encrypt that never answers.
  task automatic build_exp(input logic [2:0] mask, input bit st256);
    exp_q.delete();
    run_lens.delete();
    for (int m = 0; m < 3; m++) begin
      if (mask[m]) begin
        exp_q.push_back({1'b0, 2'(m)});
        if (!(st256 && m == 2)) exp_q.push_back({1'b1, 2'(m)});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_zero_a(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_req_valid"}, req_valid, 1'b0);
    chk({tag, "_decrypt"}, decrypt, 1'b0);
    chk({tag, "_pass"}, pass, 3'b000);
    chk({tag, "_fail"}, fail, 3'b000);
    chk({tag, "_tmo"}, tmo_err, 1'b0);
    chk({tag, "_key"}, key, 256'h0);
    chk({tag, "_data_in"}, data_in, 128'h0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic run_a(input string tag, input bit c192, input bit st256, input bit jk,
                       input int hold, input logic [2:0] exp_pass,
                       input logic [2:0] exp_fail, input logic exp_tmo);
    bit got;
    int done_at;
    corrupt192 = c192;
    stall256   = st256;
    junk_rsp   = jk;
    ready_hold = hold;
    acc256_cyc = -1;
    build_exp(3'b111, st256);
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #3;
    chk({tag, "_busy_t1"}, busy, 1'b1);
    chk({tag, "_pass_cleared"}, pass, 3'b000);
    chk({tag, "_fail_cleared"}, fail, 3'b000);
    chk({tag, "_tmo_cleared"}, tmo_err, 1'b0);
    // start while busy must not launch anything
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    done_at = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      #3;
      if (done) begin
        got = 1'b1;
        done_at = cyc;
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    repeat (6) @(negedge clk);
    #3;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_fail"}, fail, exp_fail);
    chk({tag, "_tmo"}, tmo_err, exp_tmo);
    chk({tag, "_led"}, led, exp_pass);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_state_end"}, dbg_state, ST_IDLE);
    chk({tag, "_exp_q_left"}, exp_q.size(), 0);
    if (run_lens.size() > 0) chk({tag, "_first_valid_len"}, run_lens[0], hold + 1);
    else chk({tag, "_no_requests"}, 1'b1, 1'b0);
    if (st256) chk({tag, "_tmo_latency"}, done_at - acc256_cyc, TMO + 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    int dc;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_zero_a("reset");
    chk("reset_z_busy", busy_z, 1'b0);
    chk("reset_z_done", done_z, 1'b0);
    chk("reset_z_state", dbg_state_z, ST_IDLE);
    rst_n = 1'b1;

    // All modes with a correct engine
    run_a("all_ok", 1'b0, 1'b0, 1'b0, 0, 3'b111, 3'b000, 1'b0);
    // AES-192 ciphertext bit 0 corrupted, round trip still correct
    run_a("ct192_bad", 1'b1, 1'b0, 1'b0, 0, 3'b101, 3'b010, 1'b0);
    // AES-256 encrypt never answers
    run_a("stall256", 1'b0, 1'b1, 1'b0, 0, 3'b011, 3'b100, 1'b1);
    // ready low 5 cycles on the first request, plus a stray strobe at transfer
    run_a("ready_hold", 1'b0, 1'b0, 1'b1, 5, 3'b111, 3'b000, 1'b0);

    // Reset during DEC_WAIT
    corrupt192 = 1'b0; stall256 = 1'b0; junk_rsp = 1'b0; ready_hold = 0;
    build_exp(3'b111, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      #3;
      if (dbg_state == ST_DEC_WAIT) got = 1'b1;
    end
    chk("rst_mid_reached_dec_wait", got, 1'b1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check_zero_a("rst_mid");
    repeat (2) @(negedge clk);
    #3;
    chk("rst_mid_no_done", done, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    #3;
    chk("rst_mid_done_count", done_cnt, dc);
    chk("rst_mid_idle", dbg_state, ST_IDLE);
    run_a("after_rst", 1'b0, 1'b0, 1'b0, 0, 3'b111, 3'b000, 1'b0);

    // MODE_MASK=000 instance: done at t+2, start while busy ignored
    @(negedge clk);
    start_z = 1'b1;
    @(negedge clk);
    #3;
    chk("z_busy_t1", busy_z, 1'b1);
    chk("z_done_t1", done_z, 1'b0);
    @(negedge clk);
    start_z = 1'b0;
    #3;
    chk("z_done_t2", done_z, 1'b1);
    chk("z_busy_t2", busy_z, 1'b0);
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      if (done_z) dc++;
      if (req_valid_z) dc += 100;
    end
    chk("z_no_second_run", dc, 0);
    chk("z_pass", pass_z, 3'b000);
    chk("z_fail", fail_z, 3'b000);
    chk("z_led", led_z, 3'b000);
    chk("z_tmo", tmo_err_z, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
